// File: rtl/mem_arbiter_pkg.sv
// Shared types and default address map for the instruction/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      TGT_NONE  = 2'd0,
      TGT_RAM   = 2'd1,
      TGT_HWREG = 2'd2
   } target_e;

   localparam logic [31:0] MEM_START_DEF  = 32'h0000_0000;
   localparam int unsigned MEM_SIZE_DEF   = 262144;
   localparam logic [15:0] HWREG_BASE_DEF = 16'hFF00;
   localparam int unsigned MAX_WAIT_DEF   = 4;
   localparam logic [3:0]  BE_WORD        = 4'hF;

endpackage

// File: rtl/mem_arb_decode.sv
// Address decoder: maps a byte address onto RAM, the hardware-register window, or nothing.
module mem_arb_decode
   import mem_arbiter_pkg::*;
#(
   parameter logic [31:0] MEM_START  = MEM_START_DEF,
   parameter int unsigned MEM_SIZE   = MEM_SIZE_DEF,
   parameter logic [15:0] HWREG_BASE = HWREG_BASE_DEF
) (
   input  logic [31:0] addr,
   output target_e     target
);

   localparam logic [31:0] RAM_MASK = ~(32'(MEM_SIZE) - 32'd1);

   // RAM wins when the RAM and register windows overlap
   always_comb begin
      target = TGT_NONE;
      if ((addr & RAM_MASK) == MEM_START) begin
         target = TGT_RAM;
      end else if (addr[31:16] == HWREG_BASE) begin
         target = TGT_HWREG;
      end else begin
         target = TGT_NONE;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instr/data) arbiter onto a RAM and a hardware-register bus, with a
// fixed one-cycle response and a starvation guard for instruction fetches.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [31:0] MEM_START  = MEM_START_DEF,
   parameter int unsigned MEM_SIZE   = MEM_SIZE_DEF,
   parameter logic [15:0] HWREG_BASE = HWREG_BASE_DEF,
   parameter int unsigned MAX_WAIT   = MAX_WAIT_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        hwreg_req_o,
   output logic        hwreg_we_o,
   output logic [15:0] hwreg_addr_o,
   output logic [31:0] hwreg_wdata_o,
   input  logic        hwreg_rvalid_i,
   input  logic [31:0] hwreg_rdata_i
);

   owner_e      owner_r;
   target_e     target_r;
   logic [3:0]  wait_cnt_r;
   target_e     instr_tgt_s;
   target_e     data_tgt_s;
   owner_e      next_owner_s;
   target_e     next_target_s;
   logic        force_instr_s;
   logic        instr_win_s;
   logic        data_win_s;
   logic        rsp_ok_s;
   logic [31:0] rsp_rdata_s;

   mem_arb_decode #(.MEM_START(MEM_START), .MEM_SIZE(MEM_SIZE), .HWREG_BASE(HWREG_BASE))
      u_dec_instr (.addr(instr_addr_i), .target(instr_tgt_s));

   mem_arb_decode #(.MEM_START(MEM_START), .MEM_SIZE(MEM_SIZE), .HWREG_BASE(HWREG_BASE))
      u_dec_data (.addr(data_addr_i), .target(data_tgt_s));

   // Data has priority until instr has been refused MAX_WAIT times in a row
   always_comb begin
      force_instr_s = instr_req_i && (wait_cnt_r == 4'(MAX_WAIT));
      data_win_s    = rst_ni && data_req_i && !force_instr_s;
      instr_win_s   = rst_ni && instr_req_i && !data_win_s;
   end

   assign instr_gnt_o   = instr_win_s;
   assign data_gnt_o    = data_win_s;
   assign hwreg_we_o    = data_we_i;
   assign hwreg_addr_o  = data_addr_i[15:0];
   assign hwreg_wdata_o = data_wdata_i;

   // Route the winner onto its target and record who is owed a response
   always_comb begin
      next_owner_s  = OWN_NONE;
      next_target_s = TGT_NONE;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_be_o      = data_be_i;
      mem_addr_o    = data_addr_i;
      mem_wdata_o   = data_wdata_i;
      hwreg_req_o   = 1'b0;
      if (data_win_s) begin
         next_owner_s  = OWN_DATA;
         next_target_s = data_tgt_s;
         mem_req_o     = (data_tgt_s == TGT_RAM);
         mem_we_o      = (data_tgt_s == TGT_RAM) && data_we_i;
         hwreg_req_o   = (data_tgt_s == TGT_HWREG);
      end else if (instr_win_s) begin
         // Fetches from the register window are not forwarded and answer with err
         next_owner_s  = OWN_INSTR;
         next_target_s = (instr_tgt_s == TGT_RAM) ? TGT_RAM : TGT_NONE;
         mem_req_o     = (instr_tgt_s == TGT_RAM);
         mem_be_o      = BE_WORD;
         mem_addr_o    = instr_addr_i;
      end else begin
         next_owner_s  = OWN_NONE;
         next_target_s = TGT_NONE;
      end
   end

   // Response bookkeeping and instr starvation counter
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         owner_r    <= OWN_NONE;
         target_r   <= TGT_NONE;
         wait_cnt_r <= 4'd0;
      end else begin
         owner_r  <= next_owner_s;
         target_r <= next_target_s;
         if (!instr_req_i || instr_win_s) begin
            wait_cnt_r <= 4'd0;
         end else if (wait_cnt_r < 4'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // Steer the registered target's response to the owning port
   always_comb begin
      case (target_r)
         TGT_RAM: begin
            rsp_ok_s    = mem_rvalid_i;
            rsp_rdata_s = mem_rdata_i;
         end
         TGT_HWREG: begin
            rsp_ok_s    = hwreg_rvalid_i;
            rsp_rdata_s = hwreg_rdata_i;
         end
         default: begin
            rsp_ok_s    = 1'b0;
            rsp_rdata_s = 32'h0;
         end
      endcase
      instr_rvalid_o = rst_ni && (owner_r == OWN_INSTR);
      data_rvalid_o  = rst_ni && (owner_r == OWN_DATA);
      instr_err_o    = instr_rvalid_o && !rsp_ok_s;
      data_err_o     = data_rvalid_o && !rsp_ok_s;
      instr_rdata_o  = (instr_rvalid_o && rsp_ok_s) ? rsp_rdata_s : 32'h0;
      data_rdata_o   = (data_rvalid_o && rsp_ok_s) ? rsp_rdata_s : 32'h0;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_START, default 32'h00000000, meaning RAM base address (aligned to MEM_SIZE).
REQ-002 The block SHALL have parameter MEM_SIZE, default 262144, meaning RAM size in bytes (power of two).
REQ-003 The block SHALL have parameter HWREG_BASE, default 16'hFF00, meaning addr[31:16] value that selects the hardware-register window.
REQ-004 The block SHALL have parameter MAX_WAIT, default 4, meaning consecutive denied instr cycles before instr is forced to win (1..15).
REQ-005 The block SHALL have a single clock: clk_i  in  1  clock; reset is synchronous and active-low: rst_ni  in  1  reset.
REQ-006 The block SHALL have the instr port:
- instr_req_i in 1; instr_addr_i in 32.
- instr_gnt_o out 1; instr_rvalid_o out 1; instr_rdata_o out 32; instr_err_o out 1.
REQ-007 The block SHALL have the data port:
- data_req_i in 1; data_we_i in 1; data_be_i in 4; data_addr_i in 32; data_wdata_i in 32.
- data_gnt_o out 1; data_rvalid_o out 1; data_rdata_o out 32; data_err_o out 1.
REQ-008 The block SHALL have the RAM port:
- mem_req_o out 1; mem_we_o out 1; mem_be_o out 4; mem_addr_o out 32; mem_wdata_o out 32.
- mem_rvalid_i in 1; mem_rdata_i in 32.
REQ-009 The block SHALL have the hwreg port:
- hwreg_req_o out 1; hwreg_we_o out 1; hwreg_addr_o out 16; hwreg_wdata_o out 32.
- hwreg_rvalid_i in 1; hwreg_rdata_i in 32.

Function
REQ-010 The block SHALL grant at most one requester per cycle; gnt SHALL be combinational from req in the same cycle.
REQ-011 The block SHALL give data priority, except when wait_cnt == MAX_WAIT and instr_req_i=1, in which case instr SHALL be granted and data_gnt_o held 0.
REQ-012 wait_cnt (4 bit) SHALL increment each cycle instr_req_i=1 and instr_gnt_o=0, saturate at MAX_WAIT, and clear on any instr grant or when instr_req_i=0.
REQ-013 The decode SHALL be: RAM hit if (addr & ~(MEM_SIZE-1)) == MEM_START; HWREG hit if addr[31:16] == HWREG_BASE; otherwise MISS. RAM SHALL take precedence if both hit.
REQ-014 A granted RAM hit SHALL drive mem_req_o=1 in the grant cycle, with mem_addr/be/wdata from the winner and mem_we_o = data winner & data_we_i.
REQ-015 For an instr winner, mem_be_o SHALL be 4'hF and mem_we_o SHALL be 0.
REQ-016 A granted data HWREG hit SHALL drive hwreg_req_o=1 with hwreg_addr_o = data_addr_i[15:0].
REQ-017 An instr HWREG hit or any MISS SHALL be granted without driving any target request.
REQ-018 The response SHALL occur exactly one cycle after grant: a registered {owner, target} SHALL assert the owner's rvalid, drive rdata from the registered target, and drive the other port's rvalid 0.
REQ-019 err SHALL be 1 in the response cycle if target was NONE, or if the selected target's rvalid_i=0; rdata SHALL be 32'h0 when err=1.
REQ-020 Write responses SHALL also produce rvalid (rdata don't-care, err per REQ-019).
REQ-021 Back-to-back grants SHALL be sustained at one per cycle with no bubble; response N and grant N+1 SHALL coincide.
REQ-022 When no requester is present, the block SHALL drive all target req outputs 0 and leave the registered owner NONE for the next cycle.

Reset
REQ-023 While rst_ni=0 at a clk_i edge: owner SHALL become NONE and wait_cnt SHALL become 0.
REQ-024 During reset, all gnt, rvalid, err, mem_req_o and hwreg_req_o outputs SHALL be 0, and all rdata SHALL be 0.
REQ-025 A response pending when reset asserts SHALL be dropped; no rvalid SHALL issue for it after release.

Structure
REQ-026 The shared package mem_arbiter_pkg SHALL hold owner_e {OWN_NONE, OWN_INSTR, OWN_DATA}, target_e {TGT_NONE, TGT_RAM, TGT_HWREG}, and the default address constants.
REQ-027 Address decode SHALL be a separate combinational sub-module mem_arb_decode (addr -> target_e), instantiated twice.

Verification
REQ-028 The bench SHALL cover: instr and data both requesting RAM (0x100 and 0x200) for 1 cycle -> data_gnt=1, instr_gnt=0; data_rvalid next cycle with mem_rdata.
REQ-029 The bench SHALL cover: instr held requesting, data requesting every cycle, MAX_WAIT=4 -> instr_gnt on the 5th cycle, data_gnt=0 that cycle, wait_cnt then 0.
REQ-030 The bench SHALL cover: data read 0xFF000004 with hwreg_rvalid_i=1, rdata 0x3 -> hwreg_addr_o=0x0004; next cycle data_rvalid=1, data_rdata=0x3, err=0.
REQ-031 The bench SHALL cover: data read 0x80000000 -> no mem/hwreg req; next cycle data_rvalid=1, data_err=1, rdata=0.
REQ-032 The bench SHALL cover: instr fetch 0xFF000000 -> instr_err=1 next cycle, and data write 0x10 with be=4'h3 -> mem_we=1, mem_be=4'h3.
REQ-033 The bench SHALL cover: grant data RAM read then assert rst_ni=0 on the next edge -> no data_rvalid after release, all outputs 0 during reset.
